// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one picorv32-style memory port between the instruction fetcher and
//   the data accessor. One transaction is outstanding at a time. Data wins
//   contention because the accessor holds the older instruction, but a burst
//   counter forces a waiting fetch through after MAX_DATA_BURST data grants.
//   A flush while a fetch is in flight lets the memory cycle complete and then
//   swallows its response.
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-low reset
//   i_instr_valid/i_instr_addr     fetch request
//   o_instr_ready/o_instr_rdata    one-cycle fetch response pulse + word
//   i_data_valid/i_data_addr       load/store request
//   i_data_wdata/i_data_wstrb      store data and byte enables (0 = load)
//   o_data_ready/o_data_rdata      one-cycle data response pulse + word
//   i_flush                        abandon the current or pending fetch
//   o_mem_valid/o_mem_instr        memory request, request is a fetch
//   o_mem_addr/o_mem_wdata/o_mem_wstrb  word-aligned request payload
//   i_mem_ready/i_mem_rdata        memory completion and read data
module mem_arbiter #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_instr_valid,
    input  logic [31:0] i_instr_addr,
    output logic        o_instr_ready,
    output logic [31:0] o_instr_rdata,
    input  logic        i_data_valid,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_wstrb,
    output logic        o_data_ready,
    output logic [31:0] o_data_rdata,
    input  logic        i_flush,
    output logic        o_mem_valid,
    output logic        o_mem_instr,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic [31:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);

    typedef enum logic [1:0] {IDLE, INSTR, DATA, RESP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_drop;
    logic             r_mem_valid;
    logic             r_mem_instr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;
    logic             r_instr_ready;
    logic [31:0]      r_instr_rdata;
    logic             r_data_ready;
    logic [31:0]      r_data_rdata;

    logic             w_fetch_ok;
    logic             w_grant_instr;

    // Saturating increment: the counter parks at BURST_MAX and never wraps.
    function automatic logic [CNT_W-1:0] burst_sat_inc(input logic [CNT_W-1:0] v);
        return (v == BURST_MAX) ? v : v + CNT_W'(1);
    endfunction

    // The accessor owns byte-lane placement through wstrb, so the port only
    // ever sees word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // A flush in the decision cycle suppresses the fetch but not a pending load/store.
    assign w_fetch_ok    = i_instr_valid && !i_flush;
    assign w_grant_instr = w_fetch_ok && (!i_data_valid || (r_burst_cnt == BURST_MAX));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= IDLE;
            r_burst_cnt   <= '0;
            r_drop        <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_instr   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_instr_ready <= 1'b0;
            r_instr_rdata <= '0;
            r_data_ready  <= 1'b0;
            r_data_rdata  <= '0;
        end else begin
            // Ready outputs are single-cycle pulses; only the completion edge raises them.
            r_instr_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_instr) begin
                        r_state     <= INSTR;
                        r_mem_valid <= 1'b1;
                        r_mem_instr <= 1'b1;
                        r_mem_addr  <= word_align(i_instr_addr);
                        r_mem_wstrb <= '0;
                        r_burst_cnt <= '0;
                    end else if (i_data_valid) begin
                        r_state     <= DATA;
                        r_mem_valid <= 1'b1;
                        r_mem_instr <= 1'b0;
                        r_mem_addr  <= word_align(i_data_addr);
                        r_mem_wdata <= i_data_wdata;
                        r_mem_wstrb <= i_data_wstrb;
                        // Only data grants that overtake a waiting fetch count
                        // toward the starvation bound.
                        r_burst_cnt <= i_instr_valid ? burst_sat_inc(r_burst_cnt) : '0;
                    end
                end
                INSTR: begin
                    if (i_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (i_mem_ready) begin
                        r_state     <= RESP;
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= '0;
                        // A flush on the completion cycle itself also discards the word.
                        if (!r_drop && !i_flush) begin
                            r_instr_rdata <= i_mem_rdata;
                            r_instr_ready <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_mem_ready) begin
                        r_state      <= RESP;
                        r_mem_valid  <= 1'b0;
                        r_mem_wstrb  <= '0;
                        r_data_rdata <= i_mem_rdata;
                        r_data_ready <= 1'b1;
                    end
                end
                RESP: begin
                    // Requests are ignored here so a held valid cannot re-grant
                    // during the response pulse.
                    r_drop  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_valid   = r_mem_valid;
    assign o_mem_instr   = r_mem_instr;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_wstrb   = r_mem_wstrb;
    assign o_instr_ready = r_instr_ready;
    assign o_instr_rdata = r_instr_rdata;
    assign o_data_ready  = r_data_ready;
    assign o_data_rdata  = r_data_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A transaction-level reference model
//   (bus idle / busy / responding, grant rule, burst count, drop flag) predicts
//   every cycle's outputs from the inputs the bench drove. Directed scenarios
//   are followed by a randomized run with random wait states, flushes, stray
//   mem_ready pulses and occasional resets.
module tb_mem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr_addr;
    logic        instr_ready;
    logic [31:0] instr_rdata;
    logic        data_valid;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic        flush;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_instr_valid(instr_valid),
        .i_instr_addr (instr_addr),
        .o_instr_ready(instr_ready),
        .o_instr_rdata(instr_rdata),
        .i_data_valid (data_valid),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .i_data_wstrb (data_wstrb),
        .o_data_ready (data_ready),
        .o_data_rdata (data_rdata),
        .i_flush      (flush),
        .o_mem_valid  (mem_valid),
        .o_mem_instr  (mem_instr),
        .i_mem_ready  (mem_ready),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wstrb  (mem_wstrb),
        .i_mem_rdata  (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the bus is free, carrying one transaction, or
    // delivering its response.
    typedef enum {B_IDLE, B_BUSY, B_RESP} bus_t;
    bus_t        ph = B_IDLE;
    logic        kind_instr = 1'b0;
    logic        drop = 1'b0;
    int          burst = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_wstrb = '0;
    logic [31:0] instr_shadow = '0;
    logic [31:0] data_shadow = '0;

    // Memory responder knobs.
    int          mem_wait = 0;
    int          mem_wait_cfg = -1;
    logic        stray_en = 1'b0;

    // Per-cycle events reported to the scenarios.
    int          ev_grant = 0;
    logic        ev_ir = 1'b0;
    logic        ev_dr = 1'b0;

    // Inputs the coming edge samples.
    logic        s_rst, s_iv, s_dv, s_fl, s_mr;
    logic [31:0] s_ia, s_da, s_dwd, s_mrd;
    logic [3:0]  s_dws;

    task automatic check_req(input string tag);
        check_eq({tag, "_mv"}, 32'(mem_valid), 32'd1);
        check_eq({tag, "_mi"}, 32'(mem_instr), 32'(kind_instr));
        check_eq({tag, "_addr"}, mem_addr, exp_addr);
        check_eq({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
        if (!kind_instr) check_eq({tag, "_wdata"}, mem_wdata, exp_wdata);
    endtask

    task automatic step();
        logic fetch_ok;
        s_rst = reset; s_iv = instr_valid; s_ia = instr_addr; s_dv = data_valid;
        s_da = data_addr; s_dwd = data_wdata; s_dws = data_wstrb; s_fl = flush;
        s_mr = mem_ready; s_mrd = mem_rdata;
        @(posedge clk);
        #1;
        ev_grant = 0;
        ev_ir = instr_ready;
        ev_dr = data_ready;
        if (!s_rst) begin
            ph = B_IDLE; burst = 0; drop = 1'b0;
            instr_shadow = '0; data_shadow = '0;
            check_eq("rst_ctl", 32'({mem_valid, mem_instr, instr_ready, data_ready}), 32'd0);
            check_eq("rst_addr", mem_addr, 32'd0);
            check_eq("rst_wdata", mem_wdata, 32'd0);
            check_eq("rst_wstrb", 32'(mem_wstrb), 32'd0);
            check_eq("rst_irdata", instr_rdata, 32'd0);
            check_eq("rst_drdata", data_rdata, 32'd0);
        end else begin
            case (ph)
                B_IDLE: begin
                    fetch_ok = s_iv && !s_fl;
                    if (fetch_ok && (!s_dv || burst == MAXB)) begin
                        kind_instr = 1'b1; exp_addr = {s_ia[31:2], 2'b00}; exp_wstrb = '0;
                        burst = 0; ph = B_BUSY; ev_grant = 2;
                    end else if (s_dv) begin
                        kind_instr = 1'b0; exp_addr = {s_da[31:2], 2'b00};
                        exp_wstrb = s_dws; exp_wdata = s_dwd;
                        burst = s_iv ? ((burst < MAXB) ? burst + 1 : MAXB) : 0;
                        ph = B_BUSY; ev_grant = 1;
                    end
                    if (ev_grant != 0) check_req("grant");
                    else check_eq("idle_mv", 32'(mem_valid), 32'd0);
                    check_eq("idle_rdy", 32'({instr_ready, data_ready}), 32'd0);
                end
                B_BUSY: begin
                    if (kind_instr && s_fl) drop = 1'b1;
                    if (s_mr) begin
                        ph = B_RESP;
                        check_eq("resp_mv", 32'(mem_valid), 32'd0);
                        check_eq("resp_wstrb", 32'(mem_wstrb), 32'd0);
                        if (kind_instr) begin
                            if (!drop) instr_shadow = s_mrd;
                            check_eq("resp_ir", 32'(instr_ready), 32'(!drop));
                            check_eq("resp_irdata", instr_rdata, instr_shadow);
                            check_eq("resp_dr", 32'(data_ready), 32'd0);
                        end else begin
                            data_shadow = s_mrd;
                            check_eq("resp_dr", 32'(data_ready), 32'd1);
                            check_eq("resp_drdata", data_rdata, data_shadow);
                            check_eq("resp_ir", 32'(instr_ready), 32'd0);
                        end
                    end else begin
                        check_req("hold");
                        check_eq("hold_rdy", 32'({instr_ready, data_ready}), 32'd0);
                    end
                end
                default: begin
                    ph = B_IDLE; drop = 1'b0;
                    check_eq("post_mv", 32'(mem_valid), 32'd0);
                    check_eq("post_rdy", 32'({instr_ready, data_ready}), 32'd0);
                end
            endcase
        end
        // Memory side for the cycle now starting.
        if (ph == B_BUSY) begin
            if (ev_grant != 0) mem_wait = (mem_wait_cfg < 0) ? int'($urandom_range(0, 3)) : mem_wait_cfg;
            mem_rdata = $urandom;
            if (mem_wait == 0) mem_ready = 1'b1;
            else begin
                mem_ready = 1'b0;
                mem_wait--;
            end
        end else begin
            mem_ready = stray_en && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        int n_ir, n_dr, n_gr, seq, cyc, p_cyc, g2_cyc;
        logic got;
        reset = 1'b0; instr_valid = 1'b0; instr_addr = '0; data_valid = 1'b0;
        data_addr = '0; data_wdata = '0; data_wstrb = '0; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;

        // Reset
        step(); step();
        reset = 1'b1;
        step();

        // Single fetch, two wait states, word 0x00000013
        mem_wait_cfg = 2;
        instr_valid = 1'b1; instr_addr = 32'h104;
        n_ir = 0; n_dr = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ph == B_BUSY && mem_ready) mem_rdata = 32'h0000_0013;
            if (ev_grant == 2) begin
                check_eq("fetch_addr", mem_addr, 32'h104);
                check_eq("fetch_instr", 32'(mem_instr), 32'd1);
            end
            if (ev_ir) begin
                n_ir++;
                check_eq("fetch_word", instr_rdata, 32'h0000_0013);
                instr_valid = 1'b0;
            end
            if (ev_dr) n_dr++;
        end
        check_eq("fetch_ir_cnt", 32'(n_ir), 32'd1);
        check_eq("fetch_dr_cnt", 32'(n_dr), 32'd0);

        // Contention: data first, fetch next
        mem_wait_cfg = 1;
        instr_valid = 1'b1; instr_addr = 32'h108;
        data_valid = 1'b1; data_addr = 32'h2002; data_wstrb = 4'b1100; data_wdata = 32'hAABB_0000;
        seq = 1; n_dr = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (ev_grant != 0) seq = (seq << 1) | ((ev_grant == 2) ? 1 : 0);
            if (ev_grant == 1) begin
                check_eq("cont_addr", mem_addr, 32'h2000);
                check_eq("cont_wstrb", 32'(mem_wstrb), 32'hC);
                check_eq("cont_instr", 32'(mem_instr), 32'd0);
            end
            if (ev_dr) begin n_dr++; data_valid = 1'b0; end
            if (ev_ir) instr_valid = 1'b0;
        end
        check_eq("cont_order", 32'(seq), 32'b101);
        check_eq("cont_dr_cnt", 32'(n_dr), 32'd1);

        // Starvation bound: D,D,D,D,I,D,D,D,D,I
        mem_wait_cfg = 0;
        instr_valid = 1'b1; instr_addr = 32'h200;
        data_valid = 1'b1; data_addr = 32'h3000; data_wstrb = 4'b0000;
        seq = 1; n_gr = 0;
        for (int i = 0; i < 100 && n_gr < 10; i++) begin
            step();
            if (ev_grant != 0) begin
                n_gr++;
                seq = (seq << 1) | ((ev_grant == 2) ? 1 : 0);
            end
        end
        check_eq("starve_order", 32'(seq), 32'b1_0000_1_0000_1);
        instr_valid = 1'b0; data_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Flush while the fetch is in flight
        mem_wait_cfg = 3;
        instr_valid = 1'b1; instr_addr = 32'h300;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ev_grant == 2) got = 1'b1;
        end
        check_eq("flush_grant1", 32'(got), 32'd1);
        flush = 1'b1; instr_addr = 32'h400;
        step();
        flush = 1'b0;
        n_ir = 0; n_gr = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ev_grant == 2) begin
                n_gr++;
                check_eq("flush_addr2", mem_addr, 32'h400);
            end
            if (ev_ir) begin n_ir++; instr_valid = 1'b0; end
        end
        check_eq("flush_ir_cnt", 32'(n_ir), 32'd1);
        check_eq("flush_gr_cnt", 32'(n_gr), 32'd1);

        // Reset while in DATA
        data_valid = 1'b1; data_addr = 32'h500; data_wstrb = 4'b0000;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ev_grant == 1) got = 1'b1;
        end
        check_eq("rstd_grant", 32'(got), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_eq("rstd_mv", 32'(mem_valid), 32'd0);
        check_eq("rstd_dr", 32'(data_ready), 32'd0);
        n_dr = 0; n_gr = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ev_grant == 1) n_gr++;
            if (ev_dr) begin n_dr++; data_valid = 1'b0; end
        end
        check_eq("rstd_gr_cnt", 32'(n_gr), 32'd1);
        check_eq("rstd_dr_cnt", 32'(n_dr), 32'd1);

        // Back-to-back with valid held across the response pulse
        mem_wait_cfg = 0;
        data_valid = 1'b1; data_addr = 32'h600; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
        n_gr = 0; n_dr = 0; cyc = 0; p_cyc = -100; g2_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cyc++;
            if (ev_grant != 0) begin
                n_gr++;
                if (n_gr == 2) g2_cyc = cyc;
            end
            if (ev_dr) begin
                n_dr++;
                if (n_dr == 1) begin p_cyc = cyc; data_addr = 32'h604; end
                else data_valid = 1'b0;
            end
        end
        check_eq("b2b_gr_cnt", 32'(n_gr), 32'd2);
        check_eq("b2b_gap", 32'(g2_cyc - p_cyc), 32'd2);

        // Randomized traffic
        mem_wait_cfg = -1; stray_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (flush) begin
                instr_addr = $urandom;
                instr_valid = 1'($urandom_range(0, 1));
            end else if (ev_ir) begin
                instr_valid = 1'($urandom_range(0, 1));
                instr_addr = $urandom;
            end else if (!instr_valid && $urandom_range(0, 2) == 0) begin
                instr_valid = 1'b1; instr_addr = $urandom;
            end
            if (ev_dr) begin
                data_valid = 1'($urandom_range(0, 1));
                data_addr = $urandom; data_wdata = $urandom;
                data_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end else if (!data_valid && $urandom_range(0, 2) == 0) begin
                data_valid = 1'b1; data_addr = $urandom; data_wdata = $urandom;
                data_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 149) != 0);
        end
        reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; data_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single picorv32-style memory port between the fetcher (instruction reads) and the accessor (data loads/stores). It grants one outstanding transaction at a time and gives data priority, because the accessor holds the older instruction. A bounded-burst counter guarantees fetch forward progress. Fetch responses are discarded on pipeline flush.

## Interface
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch is waiting before the fetch is forced through (≥1).
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- instr_valid  input  1  fetcher requests an instruction read
- instr_addr  input  32  fetch address
- instr_ready  output  1  one-cycle pulse: instr_rdata valid
- instr_rdata  output  32  fetched word
- data_valid  input  1  accessor requests a load/store
- data_addr  input  32  load/store address
- data_wdata  input  32  store data
- data_wstrb  input  4  byte enables; 0 = load
- data_ready  output  1  one-cycle pulse: data transaction done, data_rdata valid
- data_rdata  output  32  loaded word
- flush  input  1  decoder redirect: abandon the current or pending fetch
- mem_valid  output  1  memory request
- mem_instr  output  1  request is a fetch
- mem_ready  input  1  memory completes the request
- mem_addr  output  32  word-aligned address
- mem_wdata  output  32  write data
- mem_wstrb  output  4  write strobes
- mem_rdata  input  32  read data

## Operation
- States: IDLE, INSTR, DATA, RESP. All outputs are registered.
- Reset (reset==0 at a clk edge) has these effects:
  - State goes to IDLE and burst_cnt to 0. drop is cleared.
  - mem_valid, mem_instr, instr_ready and data_ready go to 0.
  - mem_addr, mem_wdata, mem_wstrb, instr_rdata and data_rdata go to 0.
  - Reset mid-transaction abandons it with no response. Memory must tolerate mem_valid dropping.
- Requester contract:
  - A requester holds valid, addr, wdata and wstrb stable until its ready pulse.
  - Valid may stay high after the pulse to issue a new request.
- IDLE grant decision uses the inputs of the current cycle. Define fetch_ok = instr_valid && !flush.
  - Grant INSTR if fetch_ok && (!data_valid || burst_cnt==MAX_DATA_BURST).
  - Otherwise grant DATA if data_valid.
  - Otherwise stay in IDLE.
- INSTR grant sets mem_valid=1, mem_instr=1, mem_addr={instr_addr[31:2],2'b00}, mem_wstrb=0, and clears burst_cnt.
- DATA grant sets mem_valid=1, mem_instr=0, mem_addr={data_addr[31:2],2'b00}, mem_wdata=data_wdata and mem_wstrb=data_wstrb.
  - burst_cnt increments, saturating at MAX_DATA_BURST, if instr_valid is high at the grant.
  - burst_cnt clears to 0 if instr_valid is low.
- INSTR/DATA: hold all mem_* outputs until mem_ready=1.
  - On mem_ready, mem_valid and mem_wstrb drop to 0 and the state goes to RESP.
  - mem_rdata is captured into instr_rdata or data_rdata.
  - The matching ready is pulsed in the RESP cycle.
- Flush handling:
  - flush high in any cycle while in INSTR sets drop. The memory transaction is never aborted.
  - In RESP with drop=1: instr_ready stays 0, instr_rdata is not updated, and drop clears.
  - flush has no effect on DATA.
- RESP: ready is high for exactly this cycle, and all valid inputs are ignored. Next state is IDLE.

## Timing
- IDLE grant at edge n gives mem_valid=1 from cycle n+1.
- mem_ready sampled at edge m gives the requester ready=1 during cycle m+1. The arbiter is back in IDLE at m+2.
- Minimum turnaround is 3 cycles per transaction, with zero-wait memory: grant, mem (mem_ready), RESP.
- mem_ready while not in INSTR/DATA is ignored.
- Simultaneous instr_valid and data_valid in IDLE resolve to data, unless burst_cnt==MAX_DATA_BURST.
- Simultaneous flush and instr_valid in IDLE: no fetch is granted; a pending data request still is.
- flush in the same cycle as mem_ready in INSTR: the response is dropped.
- burst_cnt never exceeds MAX_DATA_BURST and never wraps.
- Low address bits [1:0] are forced to 0. The accessor owns byte-lane alignment via wstrb.

## Test plan
- Reset then single fetch: instr_valid=1, addr=0x104, memory replies after 2 wait cycles with 0x00000013. Required:
  - mem_addr=0x104 and mem_instr=1.
  - instr_ready pulses once with instr_rdata=0x00000013.
  - data_ready stays 0.
- Contention: both valid in IDLE with data store addr=0x2002, wstrb=0b1100, wdata=0xAABB0000. Required:
  - The data grant comes first, with mem_addr=0x2000, mem_wstrb=0b1100 and mem_instr=0.
  - data_ready pulses; the fetch is granted next.
- Starvation bound, MAX_DATA_BURST=4: data_valid and instr_valid held high continuously. Grant order must be D,D,D,D,I,D,D,D,D,I.
- Flush mid-fetch: assert flush for 1 cycle while in INSTR. Required:
  - mem_valid stays high until mem_ready.
  - No instr_ready pulse occurs.
  - The next fetch (new addr 0x400) completes normally.
- Reset mid-transaction: reset=0 while in DATA. Next cycle mem_valid=0 and data_ready=0, and a later request is granted from IDLE normally.
- Back-to-back: valid held after the ready pulse with a new address. There is no duplicate grant in RESP, and the second request issues exactly 1 cycle after RESP.
